// File: rtl/frame_pkg.sv
// Shared types and default constants for the frame sequencer.
package frame_pkg;
  localparam int SUBFRAME_BITS    = 28;
  localparam int FRAMES_PER_BLOCK = 192;

  typedef enum logic [1:0] {IDLE, HUNT, RUN, FLUSH} seq_state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, used for the optional statistics.
// Compiled only when FRAME_SEQUENCER_STATS_EN is defined, so the default build has no counter flops.
`ifdef FRAME_SEQUENCER_STATS_EN
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr_i)                   cnt_q <= '0;
    else if (inc_i && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
endmodule
`endif

// File: rtl/frame_sequencer.sv
// Aligns a subframe/frame/block counter to the received bit stream and gates the dismantler.
// Define FRAME_SEQUENCER_STATS_EN to build the block_count/kill_count statistics.
module frame_sequencer #(
  parameter int SUBFRAME_BITS    = frame_pkg::SUBFRAME_BITS,
  parameter int FRAMES_PER_BLOCK = frame_pkg::FRAMES_PER_BLOCK,
  parameter int LOCK_BLOCKS      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        bit_valid,
  input  logic        sync,
  input  logic        kill,
  output logic        dm_vin,
  output logic        dm_rst,
  output logic [7:0]  frame_counter,
  output logic        channel,
  output logic        locked,
  output logic        lost_lock,
  output logic [15:0] block_count,
  output logic [7:0]  kill_count
);
  import frame_pkg::seq_state_t;
  import frame_pkg::IDLE;
  import frame_pkg::HUNT;
  import frame_pkg::RUN;
  import frame_pkg::FLUSH;

  localparam int BW = (SUBFRAME_BITS > 1) ? $clog2(SUBFRAME_BITS) : 1;
  localparam int CW = $clog2(LOCK_BLOCKS + 1);

  seq_state_t    state_q;
  logic [BW-1:0] bit_cnt_q;
  logic [7:0]    frame_q;
  logic          chan_q;
  logic          locked_q;
  logic          lost_lock_q;
  logic [CW-1:0] clean_q;
  logic          flush_q;

  logic in_run, at_boundary, kill_evt, misalign, step, sub_end, frm_end, blk_done;

  // Kill outranks everything but enable; an aligned sync is just the first bit of a block.
  assign in_run      = enable && (state_q == RUN);
  assign at_boundary = (bit_cnt_q == '0) && (frame_q == '0) && !chan_q;
  assign kill_evt    = in_run && kill;
  assign misalign    = in_run && !kill && sync && bit_valid && !at_boundary;
  assign step        = in_run && !kill && !misalign && bit_valid;
  assign sub_end     = step && (bit_cnt_q == BW'(SUBFRAME_BITS - 1));
  assign frm_end     = sub_end && chan_q;
  assign blk_done    = frm_end && (frame_q == 8'(FRAMES_PER_BLOCK - 1));

  always_ff @(posedge clk) begin
    lost_lock_q <= 1'b0;
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      chan_q    <= 1'b0;
      locked_q  <= 1'b0;
      clean_q   <= '0;
      flush_q   <= 1'b0;
    end else if (!enable) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      chan_q    <= 1'b0;
      locked_q  <= 1'b0;
      clean_q   <= '0;
    end else begin
      case (state_q)
        IDLE: state_q <= HUNT;
        HUNT: begin
          if (sync && bit_valid) begin
            state_q   <= RUN;
            bit_cnt_q <= BW'(1);
            frame_q   <= '0;
            chan_q    <= 1'b0;
          end
        end
        RUN: begin
          if (kill_evt || misalign) begin
            state_q     <= FLUSH;
            flush_q     <= 1'b0;
            bit_cnt_q   <= '0;
            frame_q     <= '0;
            chan_q      <= 1'b0;
            locked_q    <= 1'b0;
            clean_q     <= '0;
            lost_lock_q <= locked_q;
          end else if (step) begin
            if (sub_end) begin
              bit_cnt_q <= '0;
              chan_q    <= !chan_q;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            if (frm_end) frame_q <= blk_done ? 8'd0 : frame_q + 8'd1;
            if (blk_done) begin
              if (clean_q != CW'(LOCK_BLOCKS)) clean_q <= clean_q + 1'b1;
              if (clean_q >= CW'(LOCK_BLOCKS - 1)) locked_q <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (flush_q) state_q <= HUNT;
          else         flush_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    dm_vin = 1'b0;
    case (state_q)
      HUNT:    dm_vin = sync && bit_valid;
      RUN:     dm_vin = bit_valid;
      default: dm_vin = 1'b0;
    endcase
  end

  assign dm_rst        = (state_q == IDLE) || (state_q == FLUSH);
  assign frame_counter = frame_q;
  assign channel       = chan_q;
  assign locked        = locked_q;
  assign lost_lock     = lost_lock_q;

`ifdef FRAME_SEQUENCER_STATS_EN
  sat_counter #(.W(16)) u_block_cnt (
    .clk   (clk),
    .clr_i (!rst_n),
    .inc_i (blk_done),
    .cnt_o (block_count)
  );

  sat_counter #(.W(8)) u_kill_cnt (
    .clk   (clk),
    .clr_i (!rst_n),
    .inc_i (kill_evt),
    .cnt_o (kill_count)
  );
`else
  assign block_count = '0;
  assign kill_count  = '0;
`endif
endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: vector table for state gating, scoreboard for streaming.
module tb_frame_sequencer;
`ifdef FRAME_SEQUENCER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int SB   = 28;
  localparam int FPB  = 192;
  localparam int BLK  = 2 * SB * FPB;

  logic clk = 1'b0;
  logic rst_n, enable, bit_valid, sync, kill;
  logic dm_vin, dm_rst, channel, locked, lost_lock;
  logic [7:0]  frame_counter, kill_count;
  logic [15:0] block_count;

  always #5 clk = ~clk;

  frame_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .bit_valid     (bit_valid),
    .sync          (sync),
    .kill          (kill),
    .dm_vin        (dm_vin),
    .dm_rst        (dm_rst),
    .frame_counter (frame_counter),
    .channel       (channel),
    .locked        (locked),
    .lost_lock     (lost_lock),
    .block_count   (block_count),
    .kill_count    (kill_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle; dm_vin/dm_rst are captured before the edge, registered outputs after it.
  logic vin_s, rst_s;
  task automatic cyc(input logic en, input logic bv, input logic sy, input logic kl);
    enable = en; bit_valid = bv; sync = sy; kill = kl;
    #1;
    vin_s = dm_vin;
    rst_s = dm_rst;
    @(posedge clk);
    #2;
  endtask

  typedef struct packed {
    logic [7:0] fc;
    logic       ch;
    logic       vin;
  } exp_t;
  exp_t sbq[$];
  int   sidx;
  int   wraps;

  function automatic exp_t model(input int s, input logic vin);
    exp_t e;
    e.fc  = 8'((s / (2 * SB)) % FPB);
    e.ch  = 1'((s / SB) % 2);
    e.vin = vin;
    return e;
  endfunction

  // Stream n strobes with an idle gap before every eighth one; checks at subframe edges and gaps.
  task automatic stream(input int n, input bit sync_first);
    exp_t e;
    logic [7:0] prev;
    for (int i = 0; i < n; i++) begin
      if ((i % 8) == 7) begin
        sbq.push_back(model(sidx, 1'b0));
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        e = sbq.pop_front();
        if ((sidx % SB) <= 1 || (sidx % SB) == SB - 1) begin
          chk("gap_fc", frame_counter, e.fc);
          chk("gap_ch", channel, e.ch);
          chk("gap_vin", vin_s, e.vin);
        end
      end
      prev = frame_counter;
      sbq.push_back(model(sidx + 1, 1'b1));
      cyc(1'b1, 1'b1, sync_first && (i == 0), 1'b0);
      sidx++;
      if (prev == 8'(FPB - 1) && frame_counter == 8'd0) wraps++;
      e = sbq.pop_front();
      if ((sidx % SB) <= 1 || (sidx % SB) == SB - 1) begin
        chk("strobe_fc", frame_counter, e.fc);
        chk("strobe_ch", channel, e.ch);
        chk("strobe_vin", vin_s, e.vin);
      end
    end
  endtask

  typedef struct packed {
    logic en, bv, sy, kl;
    logic vin, rst;
  } vec_t;
  vec_t vt[11];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; bit_valid = 1'b0; sync = 1'b0; kill = 1'b0;
    @(posedge clk);
    #2;
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_dm_rst", dm_rst, 1);
    chk("rst_fc", frame_counter, 0);
    chk("rst_ch", channel, 0);
    chk("rst_locked", locked, 0);
    chk("rst_lost", lost_lock, 0);
    chk("rst_bc", block_count, 0);
    chk("rst_kc", kill_count, 0);
    enable = 1'b0; #1;
    chk("rst_vin", dm_vin, 0);
    rst_n = 1'b1;

    // en bv sy kl | vin rst  (outputs during the cycle)
    vt[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};  // IDLE, held off
    vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};  // IDLE -> HUNT
    vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};  // HUNT, kill ignored
    vt[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};  // HUNT sync -> RUN
    vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};  // RUN, no strobe
    vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};  // RUN strobe
    vt[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};  // misaligned sync -> FLUSH
    vt[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};  // FLUSH 1
    vt[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};  // FLUSH 2
    vt[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};  // HUNT
    vt[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};  // HUNT, sync without strobe
    for (int i = 0; i < 11; i++) begin
      cyc(vt[i].en, vt[i].bv, vt[i].sy, vt[i].kl);
      chk($sformatf("vec%0d_vin", i), vin_s, vt[i].vin);
      chk($sformatf("vec%0d_rst", i), rst_s, vt[i].rst);
      chk($sformatf("vec%0d_lost", i), lost_lock, 0);
    end
    chk("vec_kc", kill_count, 0);

    // Two clean blocks: first wrap without lock, lock right after the second wrap.
    sidx = 0; wraps = 0;
    stream(BLK, 1'b1);
    chk("blk1_wraps", wraps, 1);
    chk("blk1_fc", frame_counter, 0);
    chk("blk1_bc", block_count, STATS ? 1 : 0);
    chk("blk1_locked", locked, 0);
    stream(BLK - 1, 1'b1);
    chk("blk2_pre_locked", locked, 0);
    stream(1, 1'b0);
    chk("blk2_wraps", wraps, 2);
    chk("blk2_locked", locked, 1);
    chk("blk2_bc", block_count, STATS ? 2 : 0);

    // Kill at frame 50 of a locked stream.
    stream(50 * 2 * SB, 1'b0);
    chk("kill_pre_fc", frame_counter, 50);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("kill_lost", lost_lock, 1);
    chk("kill_locked", locked, 0);
    chk("kill_fc", frame_counter, 0);
    chk("kill_ch", channel, 0);
    chk("kill_rst1", dm_rst, 1);
    chk("kill_kc", kill_count, STATS ? 1 : 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("flush1_vin", vin_s, 0);
    chk("flush_lost_once", lost_lock, 0);
    chk("kill_rst2", dm_rst, 1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("flush2_vin", vin_s, 0);
    chk("kill_rst3", dm_rst, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("hunt_vin", vin_s, 0);
    chk("hunt_rst", dm_rst, 0);
    chk("hunt_fc", frame_counter, 0);

    // Misaligned sync at bit_cnt 10.
    sidx = 0;
    stream(10, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("mis_rst", dm_rst, 1);
    chk("mis_kc", kill_count, STATS ? 1 : 0);
    chk("mis_lost", lost_lock, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("mis_hunt_rst", dm_rst, 0);

    // enable drops at frame 100 together with kill.
    sidx = 0;
    stream(100 * 2 * SB, 1'b1);
    chk("dis_pre_fc", frame_counter, 100);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("dis_rst", dm_rst, 1);
    chk("dis_kc", kill_count, STATS ? 1 : 0);
    chk("dis_locked", locked, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("dis_idle_rst", dm_rst, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("dis_hunt_rst", dm_rst, 0);
    chk("dis_bc", block_count, STATS ? 2 : 0);

    // Reset while locked and mid-block: no lost_lock, everything cleared.
    sidx = 0; wraps = 0;
    stream(2 * BLK, 1'b1);
    chk("relock_wraps", wraps, 2);
    chk("relock_locked", locked, 1);
    chk("relock_bc", block_count, STATS ? 4 : 0);
    stream(300, 1'b0);
    rst_n = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b1;
    chk("mrst_lost", lost_lock, 0);
    chk("mrst_locked", locked, 0);
    chk("mrst_fc", frame_counter, 0);
    chk("mrst_ch", channel, 0);
    chk("mrst_rst", dm_rst, 1);
    chk("mrst_bc", block_count, 0);
    chk("mrst_kc", kill_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter SUBFRAME_BITS, default 28: bits per subframe (aux 4, data 20, valid, user, channel, parity).
REQ-002 Parameter FRAMES_PER_BLOCK, default 192: frames per channel-status block.
REQ-003 Parameter LOCK_BLOCKS, default 2: consecutive clean blocks needed before locked asserts.
REQ-004 clk  input  1  sole clock; all logic on posedge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 enable  input  1  run request; low forces IDLE.
REQ-007 bit_valid  input  1  strobe qualifying one received line bit.
REQ-008 sync  input  1  start-of-block marker from the preamble detector, coincident with the first bit of a block.
REQ-009 kill  input  1  CRC/parity failure pulse from the dismantler.
REQ-010 dm_vin  output  1  gated bit strobe to the dismantler.
REQ-011 dm_rst  output  1  active-high reset to the dismantler.
REQ-012 frame_counter  output  8  current frame index, 0..FRAMES_PER_BLOCK-1.
REQ-013 channel  output  1  current subframe channel, 0=A, 1=B.
REQ-014 locked  output  1  stream aligned and clean.
REQ-015 lost_lock  output  1  one-cycle pulse when locked falls because of a kill or misaligned sync.
REQ-016 block_count  output  16  completed blocks, saturating.
REQ-017 kill_count  output  8  kill events, saturating.

Function
REQ-018 The FSM SHALL have the states IDLE, HUNT, RUN and FLUSH.
REQ-019 IDLE: dm_rst=1, dm_vin=0; enable=1 -> HUNT next cycle.
REQ-020 HUNT: dm_rst=0; dm_vin=0 except when sync&bit_valid, then dm_vin=1 that cycle, bit_cnt<=1, frame_counter<=0, channel<=0, and the FSM goes to RUN.
REQ-021 RUN: dm_vin SHALL equal bit_valid combinationally, with zero latency.
REQ-022 In RUN, each bit_valid SHALL increment bit_cnt; at bit_cnt==SUBFRAME_BITS-1, bit_cnt<=0 and channel toggles.
REQ-023 When a subframe ends with channel=1, frame_counter SHALL increment, wrapping FRAMES_PER_BLOCK-1 -> 0; the wrap is a block completion.
REQ-024 frame_counter and channel are registered and SHALL update the cycle after the accepting strobe, staying stable until the next strobe.
REQ-025 In RUN, sync&bit_valid while not at a block boundary (bit_cnt, frame_counter and channel not all 0) SHALL count as a misaligned sync -> FLUSH.
REQ-026 Within a single RUN cycle, kill takes priority over bit counting; kill SHALL trigger FLUSH.
REQ-027 FLUSH: dm_rst=1 and dm_vin=0 for exactly 2 cycles, then HUNT; bit_cnt, frame_counter and channel SHALL clear.
REQ-028 The clean-block counter SHALL increment on each block completion with no kill since the last boundary; at LOCK_BLOCKS, locked<=1.
REQ-029 Entry to FLUSH or IDLE SHALL clear locked and the clean-block counter; lost_lock pulses only if locked was 1.
REQ-030 Each kill SHALL increment kill_count, and each block completion SHALL increment block_count; both saturate at all-ones.
REQ-031 enable=0 in any state SHALL force IDLE on the next cycle, overriding kill and sync.
REQ-032 kill outside RUN SHALL be ignored and not counted.

Reset
REQ-033 rst_n=0 at a clock edge SHALL give: state=IDLE, dm_rst=1, dm_vin=0, frame_counter=0, channel=0, locked=0, lost_lock=0, counters=0.
REQ-034 Reset mid-block SHALL abandon the block with no lost_lock pulse.

Configuration
REQ-035 Macro FRAME_SEQUENCER_STATS_EN SHALL control the statistics counters.
REQ-036 With FRAME_SEQUENCER_STATS_EN defined, block_count and kill_count SHALL be implemented per REQ-030.
REQ-037 Without FRAME_SEQUENCER_STATS_EN, block_count and kill_count SHALL be tied to 0 and no counter flops SHALL exist; all other behaviour is unchanged.

Structure
REQ-038 A shared package frame_pkg SHALL hold the seq_state_t enum (IDLE, HUNT, RUN, FLUSH) and the constants SUBFRAME_BITS=28 and FRAMES_PER_BLOCK=192.
REQ-039 The module SHALL have one sub-module, sat_counter (width parameter, increment, synchronous clear), instantiated for both statistics counters.

Verification
REQ-040 Reset then enable=1, sync on the first bit, 2*28*192 strobes -> frame_counter wraps 191->0 once, block_count=1, locked=0.
REQ-041 Same stimulus for 2 clean blocks -> locked=1 the cycle after the second wrap.
REQ-042 Locked stream, kill pulse at frame 50 -> lost_lock pulses, dm_rst=1 for exactly 2 cycles, state HUNT, kill_count=1, frame_counter=0.
REQ-043 In RUN at bit_cnt=10, assert sync&bit_valid -> FLUSH, with no kill counted.
REQ-044 enable drops at frame 100 while kill is asserted the same cycle -> IDLE, kill_count unchanged, dm_rst=1.
REQ-045 Build without FRAME_SEQUENCER_STATS_EN and rerun REQ-040..042 -> counters read 0, and all other outputs match the stats build.
